apb_cmd_master: RTL and testbench
=================================

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: max ACCESS-phase cycles awaiting pready; 0 disables timeout.
REQ-002 pclkg  input  1  sole clock; all state updates on rising edge.
REQ-003 presetn  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid&cmd_ready.
REQ-006 cmd_write  input  1  1=write, 0=read.
REQ-007 cmd_addr  input  [11:2]  word address.
REQ-008 cmd_wdata  input  32  write data.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  response consumed when rsp_valid&rsp_ready.
REQ-011 rsp_rdata  output  32  read data; 0 for writes and timeouts.
REQ-012 rsp_err  output  1  pslverr or timeout.
REQ-013 rsp_timeout  output  1  transfer ended by timeout.
REQ-014 psel, penable, pwrite  output  1 each  APB control.
REQ-015 paddr  output  [11:2]; pwdata  output  32; prdata  input  32; pready  input  1; pslverr  input  1.

Function
REQ-016 FSM states IDLE, SETUP, ACCESS; reset state IDLE.
REQ-017 cmd_ready = (state==IDLE) && (!rsp_valid || rsp_ready), combinational.
REQ-018 On acceptance at edge T: cmd fields captured; edge T+1 enters SETUP (psel=1, penable=0).
REQ-019 SETUP always advances to ACCESS next edge (psel=1, penable=1).
REQ-020 ACCESS holds until pready=1 sampled, or timeout; pwrite/paddr/pwdata stable from SETUP through last ACCESS cycle.
REQ-021 On pready=1 in ACCESS: rsp_rdata=prdata (reads) else 0, rsp_err=pslverr, rsp_timeout=0, rsp_valid=1, state IDLE, psel=penable=0 on same edge.
REQ-022 Minimum latency: cmd accepted edge T, pready=1 in first ACCESS cycle -> rsp_valid high after edge T+3.
REQ-023 Timeout counter clears entering ACCESS, increments per ACCESS cycle with pready=0; reaching TIMEOUT_CYCLES ends transfer: rsp_err=1, rsp_timeout=1, rsp_rdata=0, state IDLE.
REQ-024 pready=1 in the cycle the counter reaches TIMEOUT_CYCLES: pready wins, normal completion.
REQ-025 rsp_* held stable while rsp_valid=1 and rsp_ready=0; rsp_valid clears on handshake unless a new response loads the same edge.
REQ-026 Back-to-back: rsp handshake and new cmd acceptance allowed in the same cycle; no APB idle cycle beyond the mandatory IDLE state.
REQ-027 pslverr, prdata ignored outside ACCESS with pready=1.
REQ-028 psel never asserted without a captured command; penable never high without psel.

Reset
REQ-029 presetn low: state IDLE, psel=penable=pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, counter=0, immediately and asynchronously.
REQ-030 Reset mid-transfer aborts it; no response generated for aborted command.
REQ-031 Reset deassertion takes effect on first rising pclkg edge after release.

Structure
REQ-032 Package apb_pkg holds FSM state enum, APB_ADDR_LSB=2, APB_ADDR_MSB=11, APB_DATA_W=32.
REQ-033 Single sub-module apb_timeout_cnt: clear/enable/terminal-count counter sized $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-034 Write 0x3A5 <- 0xDEADBEEF, pready=1 immediately -> psel T+1, penable T+2, pwdata stable, rsp_valid T+3, rsp_err=0.
REQ-035 Read 0x010, pready low 3 ACCESS cycles, prdata=0x12345678 -> rsp_rdata=0x12345678, penable high 4 cycles.
REQ-036 Read with pslverr=1, pready=1 -> rsp_err=1, rsp_timeout=0.
REQ-037 pready held 0, TIMEOUT_CYCLES=16 -> transfer ends after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-038 rsp_ready low 5 cycles with cmd_valid high -> cmd_ready=0, rsp stable; rsp_ready high -> next cmd accepted same cycle.
REQ-039 presetn low during ACCESS -> psel/penable drop asynchronously, no rsp_valid after release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB master types: bus field widths and the transfer FSM encoding.
package apb_pkg;

    localparam int APB_ADDR_LSB = 2;
    localparam int APB_ADDR_MSB = 11;
    localparam int APB_DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter; tc_o flags the enabled cycle that would make the count reach MAX_COUNT.
// Single-cycle clear/increment, saturates at MAX_COUNT; MAX_COUNT=0 never raises tc_o.
module apb_timeout_cnt #(
    parameter int MAX_COUNT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (MAX_COUNT > 0) ? CW'(MAX_COUNT - 1) : '0;
    localparam logic [CW-1:0] CNT_FULL = CW'(MAX_COUNT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_FULL)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (MAX_COUNT > 0) && en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/apb_cmd_master.sv
// Command-to-APB bridge: one transfer at a time, response after SETUP + ACCESS (min 3 cycles from cmd cycle).
// cmd_ready only in IDLE with the response slot free or draining; rsp held until rsp_ready.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                               pclkg,
    input  logic                               presetn,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic                               cmd_write,
    input  logic [APB_ADDR_MSB:APB_ADDR_LSB]   cmd_addr,
    input  logic [APB_DATA_W-1:0]              cmd_wdata,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [APB_DATA_W-1:0]              rsp_rdata,
    output logic                               rsp_err,
    output logic                               rsp_timeout,
    output logic                               psel,
    output logic                               penable,
    output logic                               pwrite,
    output logic [APB_ADDR_MSB:APB_ADDR_LSB]   paddr,
    output logic [APB_DATA_W-1:0]              pwdata,
    input  logic [APB_DATA_W-1:0]              prdata,
    input  logic                               pready,
    input  logic                               pslverr
);

    apb_state_e                      state_q, state_d;
    logic                            pwrite_q;
    logic [APB_ADDR_MSB:APB_ADDR_LSB] paddr_q;
    logic [APB_DATA_W-1:0]           pwdata_q;
    logic                            rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_W-1:0]           rsp_rdata_q, rsp_rdata_d;
    logic                            rsp_err_q, rsp_err_d;
    logic                            rsp_timeout_q, rsp_timeout_d;
    logic                            cmd_fire;
    logic                            cnt_clr, cnt_en, cnt_tc;

    assign cmd_ready = (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
    assign cmd_fire  = cmd_valid && cmd_ready;

    apb_timeout_cnt #(
        .MAX_COUNT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i  (pclkg),
        .rst_ni (presetn),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .tc_o   (cnt_tc)
    );

    always_comb begin
        state_d       = state_q;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;
        rsp_valid_d   = rsp_valid_q && !rsp_ready;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_clr = 1'b1;
            end
            ACCESS: begin
                // pready is checked first so it wins over a same-cycle timeout.
                if (pready) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_tc) begin
                        state_d       = IDLE;
                        rsp_valid_d   = 1'b1;
                        rsp_rdata_d   = '0;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclkg or negedge presetn) begin
        if (!presetn) begin
            state_q       <= IDLE;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            if (cmd_fire) begin
                pwrite_q <= cmd_write;
                paddr_q  <= cmd_addr;
                pwdata_q <= cmd_wdata;
            end
        end
    end

    assign psel        = (state_q != IDLE);
    assign penable     = (state_q == ACCESS);
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: per-scenario tasks with hand-computed expectations.
module tb_apb_cmd_master;

    logic        pclkg = 1'b0;
    logic        presetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:2] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [11:2] paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 pclkg = ~pclkg;

    apb_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
        .pclkg(pclkg), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // Drive a command one step after an edge, let the next edge take it, then drop cmd_valid.
    // Returns one step after the handshake edge, i.e. in the SETUP cycle.
    task automatic issue_cmd(input logic wr, input logic [11:2] addr, input logic [31:0] wdata);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        for (int i = 0; i < 20 && !cmd_ready; i++) begin
            @(posedge pclkg); #1;
        end
        @(posedge pclkg); #1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    endtask

    // Reactive slave: holds pready low for n_wait ACCESS cycles, then completes.
    // Noise on prdata/pslverr outside the completing cycle must be ignored by the DUT.
    task automatic run_access(input int n_wait, input logic [31:0] rdata, input logic slverr,
                              output int en_cycles, output logic got_rsp);
        en_cycles = 0; got_rsp = 1'b0;
        for (int i = 0; i < 64 && !got_rsp; i++) begin
            if (penable) begin
                pready  = (en_cycles == n_wait);
                prdata  = pready ? rdata : 32'hFFFF_FFFF;
                pslverr = pready ? slverr : 1'b1;
                en_cycles++;
            end else begin
                pready = 1'b0; prdata = 32'hA5A5_A5A5; pslverr = 1'b1;
            end
            @(posedge pclkg); #1;
            got_rsp = rsp_valid;
        end
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge pclkg); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        #3;
        n_checks++; if (psel !== 1'b0)      begin n_fail++; $display("FAIL reset_psel: got %0b want 0", psel); end
        n_checks++; if (penable !== 1'b0)   begin n_fail++; $display("FAIL reset_penable: got %0b want 0", penable); end
        n_checks++; if (pwrite !== 1'b0)    begin n_fail++; $display("FAIL reset_pwrite: got %0b want 0", pwrite); end
        n_checks++; if (paddr !== 10'h000)  begin n_fail++; $display("FAIL reset_paddr: got %h want 000", paddr); end
        n_checks++; if (pwdata !== 32'h0)   begin n_fail++; $display("FAIL reset_pwdata: got %h want 0", pwdata); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
        n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        n_checks++; if (rsp_err !== 1'b0)   begin n_fail++; $display("FAIL reset_rsp_err: got %0b want 0", rsp_err); end
        n_checks++; if (rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_timeout: got %0b want 0", rsp_timeout); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
        @(posedge pclkg); @(posedge pclkg); #2;
        presetn = 1'b1;
        @(posedge pclkg); #1;
    endtask

    task automatic test_write();
        // Edge T is the edge just passed; the command is presented in the cycle after it.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h3A5; cmd_wdata = 32'hDEAD_BEEF;
        #1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL wr_cmd_ready: got %0b want 1", cmd_ready); end
        @(posedge pclkg); #1;  // T+1
        cmd_valid = 1'b0; cmd_wdata = '0; cmd_addr = '0;
        pready = 1'b1;         // ignored in SETUP, completes the first ACCESS cycle
        n_checks++; if ({psel, penable} !== 2'b10) begin n_fail++; $display("FAIL wr_setup_T1: got psel/penable %b want 10", {psel, penable}); end
        n_checks++; if (paddr !== 10'h3A5 || pwrite !== 1'b1) begin n_fail++; $display("FAIL wr_setup_addr: got %h/%0b want 3a5/1", paddr, pwrite); end
        n_checks++; if (pwdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_setup_pwdata: got %h want deadbeef", pwdata); end
        @(posedge pclkg); #1;  // T+2
        n_checks++; if ({psel, penable} !== 2'b11) begin n_fail++; $display("FAIL wr_access_T2: got psel/penable %b want 11", {psel, penable}); end
        n_checks++; if (pwdata !== 32'hDEAD_BEEF || paddr !== 10'h3A5) begin n_fail++; $display("FAIL wr_access_stable: got %h/%h want deadbeef/3a5", pwdata, paddr); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_early: got %0b want 0", rsp_valid); end
        @(posedge pclkg); #1;  // T+3
        pready = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wr_rsp_T3: got %0b want 1", rsp_valid); end
        n_checks++; if ({rsp_err, rsp_timeout} !== 2'b00 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rsp_fields: got err/to %b rdata %h want 00/0", {rsp_err, rsp_timeout}, rsp_rdata); end
        n_checks++; if ({psel, penable} !== 2'b00) begin n_fail++; $display("FAIL wr_idle_T3: got psel/penable %b want 00", {psel, penable}); end
        consume();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_consumed: got %0b want 0", rsp_valid); end
    endtask

    task automatic test_read_wait();
        int en; logic got;
        issue_cmd(1'b0, 10'h010, 32'h0);
        run_access(3, 32'h1234_5678, 1'b0, en, got);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL rd_wait_rsp: got %0b want 1", got); end
        n_checks++; if (en != 4) begin n_fail++; $display("FAIL rd_wait_penable_cycles: got %0d want 4", en); end
        n_checks++; if (rsp_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_wait_rdata: got %h want 12345678", rsp_rdata); end
        n_checks++; if ({rsp_err, rsp_timeout} !== 2'b00) begin n_fail++; $display("FAIL rd_wait_err: got %b want 00", {rsp_err, rsp_timeout}); end
        consume();
    endtask

    task automatic test_slverr();
        int en; logic got;
        issue_cmd(1'b0, 10'h004, 32'h0);
        run_access(0, 32'h0000_0055, 1'b1, en, got);
        n_checks++; if (got !== 1'b1 || en != 1) begin n_fail++; $display("FAIL slverr_done: got rsp %0b cycles %0d want 1/1", got, en); end
        n_checks++; if ({rsp_err, rsp_timeout} !== 2'b10) begin n_fail++; $display("FAIL slverr_flags: got err/to %b want 10", {rsp_err, rsp_timeout}); end
        n_checks++; if (rsp_rdata !== 32'h0000_0055) begin n_fail++; $display("FAIL slverr_rdata: got %h want 00000055", rsp_rdata); end
        consume();
    endtask

    task automatic test_timeout();
        int en; logic got;
        issue_cmd(1'b0, 10'h020, 32'h0);
        run_access(1000, 32'h0, 1'b0, en, got);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL tmo_rsp: got %0b want 1", got); end
        n_checks++; if (en != 16) begin n_fail++; $display("FAIL tmo_access_cycles: got %0d want 16", en); end
        n_checks++; if ({rsp_err, rsp_timeout} !== 2'b11) begin n_fail++; $display("FAIL tmo_flags: got err/to %b want 11", {rsp_err, rsp_timeout}); end
        n_checks++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL tmo_rdata: got %h want 0", rsp_rdata); end
        n_checks++; if ({psel, penable} !== 2'b00) begin n_fail++; $display("FAIL tmo_idle: got psel/penable %b want 00", {psel, penable}); end
        consume();
    endtask

    task automatic test_back_to_back();
        int en; logic got;
        issue_cmd(1'b1, 10'h0AA, 32'h0000_0001);
        run_access(0, 32'h0, 1'b0, en, got);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL bp_first_rsp: got %0b want 1", got); end
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h0BB; cmd_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_cmd_ready_c%0d: got %0b want 0", i, cmd_ready); end
            n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || psel !== 1'b0)
                begin n_fail++; $display("FAIL bp_rsp_hold_c%0d: got vld %0b err %0b rdata %h psel %0b want 1/0/0/0", i, rsp_valid, rsp_err, rsp_rdata, psel); end
            @(posedge pclkg);
        end
        #1;
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_cmd_ready_release: got %0b want 1", cmd_ready); end
        @(posedge pclkg); #1;
        rsp_ready = 1'b0; cmd_valid = 1'b0; cmd_addr = '0;
        n_checks++; if (rsp_valid !== 1'b0 || psel !== 1'b1 || penable !== 1'b0)
            begin n_fail++; $display("FAIL bp_same_edge: got vld %0b psel %0b penable %0b want 0/1/0", rsp_valid, psel, penable); end
        n_checks++; if (paddr !== 10'h0BB || pwrite !== 1'b0) begin n_fail++; $display("FAIL bp_second_addr: got %h/%0b want 0bb/0", paddr, pwrite); end
        run_access(1, 32'hCAFE_F00D, 1'b0, en, got);
        n_checks++; if (got !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL bp_second_rdata: got %0b/%h want 1/cafef00d", got, rsp_rdata); end
        consume();
    endtask

    task automatic test_reset_mid();
        int seen;
        issue_cmd(1'b0, 10'h030, 32'h0);
        @(posedge pclkg); #1;
        n_checks++; if ({psel, penable} !== 2'b11) begin n_fail++; $display("FAIL rstmid_access: got psel/penable %b want 11", {psel, penable}); end
        #1;
        presetn = 1'b0;
        #1;
        n_checks++; if ({psel, penable} !== 2'b00) begin n_fail++; $display("FAIL rstmid_async_drop: got psel/penable %b want 00", {psel, penable}); end
        n_checks++; if (paddr !== 10'h000) begin n_fail++; $display("FAIL rstmid_paddr: got %h want 000", paddr); end
        @(posedge pclkg); #2;
        presetn = 1'b1;
        pready = 1'b1; prdata = 32'h7777_7777;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge pclkg); #1;
            if (rsp_valid === 1'b1 || psel === 1'b1) seen++;
        end
        pready = 1'b0; prdata = '0;
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_no_rsp: got %0d active cycles want 0", seen); end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
